// File: rtl/bubble_sort_pkg.sv
// Shared types and sizing helpers for the bubble-sort engine.
package bubble_sort_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SORT   = 2'd1,
        UNLOAD = 2'd2
    } state_e;

    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_DEPTH     = 8;

    // Enough bits to hold the worst-case swap total DEPTH*(DEPTH-1)/2.
    function automatic int swap_cnt_width(input int depth);
        return $clog2(depth * (depth - 1) / 2 + 1);
    endfunction

endpackage

// File: rtl/bubble_sort_ctrl_dp_comp.sv
// Combinational unsigned magnitude comparator; exactly one of lt/gt/eq is high.
module dp_comp #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 lt,
    output logic                 gt,
    output logic                 eq
);

    assign lt = (a < b);
    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Block bubble sorter: loads DEPTH words, sorts in place one compare per cycle,
// then streams the block out in ascending order.
//   state  | meaning
//   LOAD   | accepting input words into mem[idx]
//   SORT   | comparing mem[idx] / mem[idx+1], swapping on greater-than
//   UNLOAD | presenting mem[idx] on the output stream
module bubble_sort_ctrl
    import bubble_sort_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic [DATAWIDTH-1:0]               in_data,
    output logic                               in_ready,
    output logic                               out_valid,
    output logic [DATAWIDTH-1:0]               out_data,
    input  logic                               out_ready,
    output logic                               busy,
    output logic                               sort_done,
    output logic [swap_cnt_width(DEPTH)-1:0]   swap_count
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SCW = swap_cnt_width(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [IW-1:0] PASS_MAX = IW'(DEPTH - 2);

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [IW-1:0]          pass_q, pass_d;
    logic                   swapped_q, swapped_d;
    logic [SCW-1:0]         swap_count_q, swap_count_d;
    logic [DATAWIDTH-1:0]   mem_q [DEPTH];
    logic [DATAWIDTH-1:0]   mem_d [DEPTH];

    logic [IW-1:0]          idx_p1;
    logic [IW-1:0]          last_idx;
    logic [DATAWIDTH-1:0]   cmp_a, cmp_b;
    logic                   cmp_lt, cmp_gt, cmp_eq;
    logic                   do_swap;
    logic                   swap_seen;

    assign idx_p1   = idx_q + 1'b1;
    assign last_idx = PASS_MAX - pass_q;
    assign cmp_a    = mem_q[idx_q];
    assign cmp_b    = mem_q[idx_p1];

    dp_comp #(
        .DATAWIDTH(DATAWIDTH)
    ) u_comp (
        .a  (cmp_a),
        .b  (cmp_b),
        .lt (cmp_lt),
        .gt (cmp_gt),
        .eq (cmp_eq)
    );

    // Equal keys must never move, which keeps the sort stable.
    assign do_swap = cmp_gt & ~cmp_lt & ~cmp_eq;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pass_d       = pass_q;
        swapped_d    = swapped_q;
        swap_count_d = swap_count_q;
        mem_d        = mem_q;
        sort_done    = 1'b0;
        swap_seen    = 1'b0;

        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    mem_d[idx_q] = in_data;
                    if (idx_q == '0) begin
                        swap_count_d = '0;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d   = SORT;
                        idx_d     = '0;
                        pass_d    = '0;
                        swapped_d = 1'b0;
                    end else begin
                        idx_d = idx_p1;
                    end
                end
            end

            SORT: begin
                if (do_swap) begin
                    mem_d[idx_q]  = cmp_b;
                    mem_d[idx_p1] = cmp_a;
                    swap_count_d  = swap_count_q + 1'b1;
                end
                swap_seen = swapped_q | do_swap;
                if (idx_q == last_idx) begin
                    // A clean pass or the final pass ends the sort without a bubble cycle.
                    if (!swap_seen || (pass_q == PASS_MAX)) begin
                        state_d   = UNLOAD;
                        idx_d     = '0;
                        sort_done = 1'b1;
                    end else begin
                        pass_d    = pass_q + 1'b1;
                        idx_d     = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    idx_d     = idx_p1;
                    swapped_d = swap_seen;
                end
            end

            UNLOAD: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = LOAD;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_p1;
                    end
                end
            end

            default: begin
                state_d = LOAD;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            idx_q        <= '0;
            pass_q       <= '0;
            swapped_q    <= 1'b0;
            swap_count_q <= '0;
            mem_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pass_q       <= pass_d;
            swapped_q    <= swapped_d;
            swap_count_q <= swap_count_d;
            mem_q        <= mem_d;
        end
    end

    assign in_ready   = (state_q == LOAD);
    assign out_valid  = (state_q == UNLOAD);
    assign busy       = (state_q == SORT);
    assign out_data   = (state_q == UNLOAD) ? mem_q[idx_q] : '0;
    assign swap_count = swap_count_q;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench for bubble_sort_ctrl with DATAWIDTH=8, DEPTH=8.
module tb_bubble_sort_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       sort_done;
    logic [4:0] swap_count;

    int n_vec;
    int n_miss;

    bubble_sort_ctrl #(
        .DATAWIDTH(8),
        .DEPTH    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .sort_done  (sort_done),
        .swap_count (swap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference bubble sort with early exit; reports swaps and compare count.
    task automatic ref_sort(input logic [7:0] v [8], output logic [7:0] s [8],
                            output int swaps, output int compares);
        logic [7:0] t;
        bit sw;
        s = v;
        swaps = 0;
        compares = 0;
        for (int p = 0; p < 7; p++) begin
            sw = 1'b0;
            for (int i = 0; i <= 6 - p; i++) begin
                compares++;
                if (s[i] > s[i+1]) begin
                    t = s[i]; s[i] = s[i+1]; s[i+1] = t;
                    swaps++;
                    sw = 1'b1;
                end
            end
            if (!sw) break;
        end
    endtask

    task automatic load_block(input logic [7:0] v [8], input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
                tick();
            end
            if (i == 7) check("in_ready_before_last", in_ready, 1);
            in_valid = 1'b1;
            in_data  = v[i];
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        check("in_ready_after_load", in_ready, 0);
    endtask

    task automatic run_sort(input string tag, input int exp_busy, input int exp_swaps);
        int busy_cnt;
        int done_cnt;
        int cyc;
        busy_cnt = 0;
        done_cnt = 0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            if (busy) busy_cnt++;
            if (sort_done) done_cnt++;
            tick();
            cyc++;
        end
        check({tag, "_timeout"}, (cyc < 200), 1);
        check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_vs_valid"}, sort_done, 0);
        check({tag, "_swap_count"}, swap_count, exp_swaps);
    endtask

    // mode 0: out_ready always high; mode 1: random with a 10-cycle hold on word 3.
    task automatic unload_block(input string tag, input logic [7:0] exp [8], input int mode);
        logic [7:0] got [8];
        logic [7:0] prev_data;
        bit stall_prev;
        int n_got;
        int cyc;
        int hold_cnt;
        n_got = 0;
        cyc = 0;
        hold_cnt = 0;
        stall_prev = 1'b0;
        prev_data = 8'h00;
        while (n_got < 8 && cyc < 400) begin
            if (mode == 0) begin
                out_ready = 1'b1;
            end else if (n_got == 2 && hold_cnt < 10) begin
                out_ready = 1'b0;
                hold_cnt++;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            check({tag, "_in_ready_low"}, in_ready, 0);
            if (stall_prev && out_valid) check({tag, "_stall_stable"}, out_data, prev_data);
            if (out_valid && out_ready) begin
                got[n_got] = out_data;
                n_got++;
                stall_prev = 1'b0;
            end else begin
                stall_prev = out_valid;
                prev_data  = out_data;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check({tag, "_unload_timeout"}, (cyc < 400), 1);
        for (int i = 0; i < 8; i++) begin
            if (i < n_got) check($sformatf("%s_word%0d", tag, i), got[i], exp[i]);
        end
        check({tag, "_word_count"}, n_got, 8);
        check({tag, "_in_ready_back"}, in_ready, 1);
        check({tag, "_out_valid_off"}, out_valid, 0);
        if (mode == 1) check({tag, "_hold_applied"}, hold_cnt, 10);
    endtask

    initial begin
        logic [7:0] blk [8];
        logic [7:0] srt [8];
        logic [7:0] asc [8];
        int r_swaps;
        int r_cmps;

        n_vec = 0;
        n_miss = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sort_done", sort_done, 0);
        check("rst_swap_count", swap_count, 0);
        check("rst_out_data", out_data, 0);

        asc = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};

        // Worst case: strictly descending.
        blk = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_block(blk, 1'b0);
        run_sort("desc", 28, 28);
        unload_block("desc", asc, 0);

        // Best case: already sorted.
        load_block(asc, 1'b0);
        run_sort("sorted", 7, 0);
        unload_block("sorted", asc, 0);

        // Duplicates: stable, 12 inversions.
        blk = '{8'd5, 8'd3, 8'd5, 8'd0, 8'd255, 8'd3, 8'd0, 8'd255};
        srt = '{8'd0, 8'd0, 8'd3, 8'd3, 8'd5, 8'd5, 8'd255, 8'd255};
        ref_sort(blk, asc, r_swaps, r_cmps);
        check("dup_model_inversions", r_swaps, 12);
        load_block(blk, 1'b0);
        run_sort("dup", r_cmps, 12);
        unload_block("dup", srt, 0);

        // Backpressure during unload.
        blk = '{8'd40, 8'd10, 8'd30, 8'd20, 8'd80, 8'd60, 8'd70, 8'd50};
        srt = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        ref_sort(blk, asc, r_swaps, r_cmps);
        load_block(blk, 1'b0);
        run_sort("bp", r_cmps, r_swaps);
        unload_block("bp", srt, 1);

        // Reset in the middle of a descending sort.
        blk = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_block(blk, 1'b0);
        repeat (4) tick();
        check("mid_busy", busy, 1);
        check("mid_swap_count", swap_count, 4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("arst_in_ready", in_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_swap_count", swap_count, 0);
        blk = '{8'd2, 8'd1, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        asc = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load_block(blk, 1'b0);
        run_sort("fresh", 13, 1);
        unload_block("fresh", asc, 0);

        // Gapped input, then in_valid held high through SORT and UNLOAD.
        blk = '{8'd9, 8'd4, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd3};
        srt = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9};
        ref_sort(blk, asc, r_swaps, r_cmps);
        load_block(blk, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h00;
        run_sort("gap", r_cmps, r_swaps);
        unload_block("gap", srt, 0);
        in_valid = 1'b0;
        tick();
        check("gap_idle_in_ready", in_ready, 1);
        check("gap_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bubble_sort_ctrl.md
# bubble_sort_ctrl

Sequencing end of the bubble-sort datapath: accepts a block of DEPTH unsigned words on a valid/ready input stream and drives pairs of stored words into the comparator. It swaps on greater-than and repeats passes until a pass makes no swap, then streams the sorted block out in ascending order on a valid/ready output. It is the initiator and consumer for the lt/gt/eq comparator and is the top-level sort engine of the design.

## Interface
- DATAWIDTH, 8, width of each element (unsigned)
- DEPTH, 8, elements per block; legal range 2..64
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, one clock, sampled on the rising edge of clk
- in_valid  in  1  input word present
- in_data  in  DATAWIDTH  input word
- in_ready  out  1  block can accept a word
- out_valid  out  1  sorted word present
- out_data  out  DATAWIDTH  sorted word, ascending order
- out_ready  in  1  downstream accepts the word
- busy  out  1  high while in SORT
- sort_done  out  1  one-cycle pulse on the SORT->UNLOAD transition
- swap_count  out  clog2(DEPTH*(DEPTH-1)/2+1)  swaps performed on the current block; holds its value until the next block's first load

## Operation
- Storage: register array mem[0..DEPTH-1]. Counters: idx (load/unload/compare index), pass, and the flag swapped.
- FSM states:
  - LOAD: in_ready=1. On in_valid&in_ready, write mem[idx] and increment idx. On the DEPTH-th word, go to SORT with idx=0, pass=0, swapped=0.
  - SORT: one compare per cycle. The comparator sees a=mem[idx], b=mem[idx+1].
    - If gt: swap the two entries at the clock edge, set swapped, increment swap_count.
    - If lt or eq: no swap. Equal keys are never swapped, so the sort is stable.
    - Last compare of a pass is at idx == DEPTH-2-pass.
      - If nothing swapped this pass (including that edge's compare), or pass == DEPTH-2: go to UNLOAD and pulse sort_done.
      - Otherwise: increment pass, set idx=0, clear swapped. No bubble cycle between passes.
  - UNLOAD: out_valid=1 and out_data=mem[idx]. On out_valid&out_ready, increment idx. After the DEPTH-th transfer, go to LOAD with idx=0.
- swap_count clears on the first accepted word of a new block.
- in_valid is ignored outside LOAD. out_ready is ignored outside UNLOAD.
- Reset is allowed in any state, including mid-pass or mid-unload. It aborts the block; the partial contents are discarded.

## Timing
- Reset values:
  - state=LOAD; in_ready=1; out_valid=0; busy=0; sort_done=0.
  - swap_count=0; out_data=0; all mem entries=0.
  - idx, pass and swapped = 0.
- Load: minimum DEPTH cycles with in_valid held high. in_ready drops on the cycle after the last word.
- Sort latency:
  - Best case (already sorted): DEPTH-1 cycles.
  - Worst case (strictly descending): DEPTH*(DEPTH-1)/2 cycles. For DEPTH=8 that is 7 and 28.
- out_valid rises the cycle after the sort_done pulse. sort_done and out_valid never overlap.
- Unload: one word per cycle while out_ready=1. out_data is stable while out_valid=1 and out_ready=0.
- in_ready rises the cycle after the last output handshake. Input and output transfers never overlap.
- The comparator is combinational. The swap decision and the write-back complete in the same cycle.

## Structure
- Package bubble_sort_pkg holds:
  - state enum {LOAD, SORT, UNLOAD};
  - default DATAWIDTH and DEPTH constants;
  - a function computing the swap_count width.
- One sub-module: a single instance of the team comparator dp_comp (DATAWIDTH parameter passed through) provides lt/gt/eq.
- FSM, counters and storage live in bubble_sort_ctrl.

## Test plan
- Descending input 8,7,6,5,4,3,2,1 with out_ready=1:
  - output 1..8;
  - swap_count=28;
  - busy high exactly 28 cycles;
  - one sort_done pulse.
- Sorted input 1..8: busy for 7 cycles, swap_count=0, output unchanged.
- Duplicates 5,3,5,0,255,3,0,255:
  - output 0,0,3,3,5,5,255,255;
  - swap_count matches the reference model's count of inversions.
- Backpressure: toggle out_ready randomly during UNLOAD, and hold out_ready=0 for 10 cycles on word 3.
  - out_data is stable while stalled;
  - no word is lost or duplicated;
  - in_ready stays 0 until the 8th handshake.
- Reset mid-operation: assert rst_n=0 for one cycle at SORT cycle 5 of a descending block.
  - Next cycle: state LOAD, in_ready=1, busy=0, swap_count=0.
  - A fresh block 2,1,... then sorts correctly.
- Gaps and ignored traffic:
  - in_valid toggling during LOAD: exactly 8 words are captured;
  - in_valid=1 during SORT/UNLOAD: ignored, no mem write.
